// File: rtl/dac_write_scheduler.sv
// Round-robin arbiter sharing one parallel DAC write port; converts two's-complement to offset-binary.
// Optional macro DAC_SYM_CLAMP_EN clamps the most-negative input to most-negative+1 before conversion.
module dac_write_scheduler #(
  parameter int N_CH       = 4,
  parameter int WIRE_WIDTH = 12,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  localparam int AW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*WIRE_WIDTH-1:0] data_in,
  output logic [N_CH-1:0]            ack,
  output logic [WIRE_WIDTH-1:0]      dac_data,
  output logic [AW-1:0]              dac_addr,
  output logic                       dac_wr_n,
  output logic                       busy
);

  localparam int M1   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAXC = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [AW-1:0]         ptr, ptr_n;
  logic [AW-1:0]         addr_n, gnt_idx;
  logic [WIRE_WIDTH-1:0] data_n, sample, conv;
  logic [N_CH-1:0]       ack_n;
  logic                  wr_n_n, hit;

  // First requester at or above the pointer, wrapping.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!hit && req[(int'(ptr) + i) % N_CH]) begin
        hit     = 1'b1;
        gnt_idx = AW'((int'(ptr) + i) % N_CH);
      end
    end
  end

  always_comb begin
    sample = data_in[int'(gnt_idx)*WIRE_WIDTH +: WIRE_WIDTH];
`ifdef DAC_SYM_CLAMP_EN
    if (sample == {1'b1, {(WIRE_WIDTH-1){1'b0}}})
      sample = {1'b1, {(WIRE_WIDTH-2){1'b0}}, 1'b1};
`endif
    conv = {~sample[WIRE_WIDTH-1], sample[WIRE_WIDTH-2:0]};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    addr_n  = dac_addr;
    data_n  = dac_data;
    ack_n   = '0;
    wr_n_n  = 1'b1;
    case (state)
      IDLE: if (hit) begin
        state_n        = SETUP;
        cnt_n          = '0;
        addr_n         = gnt_idx;
        data_n         = conv;
        ack_n[gnt_idx] = 1'b1;
        ptr_n          = (gnt_idx == AW'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
      end
      SETUP: begin
        if (cnt == CW'(SETUP_CYC-1)) begin
          state_n = STROBE;
          cnt_n   = '0;
          wr_n_n  = 1'b0;
        end else cnt_n = cnt + 1'b1;
      end
      STROBE: begin
        wr_n_n = 1'b0;
        if (cnt == CW'(STROBE_CYC-1)) begin
          state_n = HOLD;
          cnt_n   = '0;
          wr_n_n  = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      HOLD: begin
        if (cnt == CW'(HOLD_CYC-1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // wr_n is registered from next-state so it is low exactly while in STROBE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      ack      <= '0;
      dac_data <= '0;
      dac_addr <= '0;
      dac_wr_n <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      ack      <= ack_n;
      dac_data <= data_n;
      dac_addr <= addr_n;
      dac_wr_n <= wr_n_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed bench for dac_write_scheduler with a grant scoreboard checked on every cycle.
module tb_dac_write_scheduler;
  localparam int N = 4;
  localparam int W = 12;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   dac_data;
  logic [1:0]     dac_addr;
  logic           dac_wr_n, busy;

  typedef struct {int ch; logic [W-1:0] data;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cycle = 0, strobes = 0, acks_seen = 0;
  int gc[8];
  logic [W-1:0] cur_data = '0;
  logic [1:0]   cur_addr = '0;

  dac_write_scheduler #(.N_CH(N), .WIRE_WIDTH(W), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .dac_data(dac_data), .dac_addr(dac_addr), .dac_wr_n(dac_wr_n), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample at the falling edge and score any grant / strobe.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cycle++;
    if (!dac_wr_n) begin
      strobes++;
      chk("strobe_data", 32'(dac_data), 32'(cur_data));
      chk("strobe_addr", 32'(dac_addr), 32'(cur_addr));
    end
    if (ack != '0) begin
      acks_seen++;
      if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1 << e.ch));
        chk("grant_addr", 32'(dac_addr), 32'(e.ch));
        chk("grant_data", 32'(dac_data), 32'(e.data));
        cur_data = e.data;
        cur_addr = 2'(e.ch);
      end
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] d);
    exp_t e;
    e.ch = ch;
    e.data = d;
    sb.push_back(e);
  endtask

  // Wait for n grants; optionally drop each granted channel's request.
  task automatic wait_acks(input int n, input bit drop);
    int got;
    got = 0;
    for (int i = 0; i < 60 && got < n; i++) begin
      cyc();
      if (ack != '0) begin
        gc[got] = cycle;
        got++;
        if (drop) req = req & ~ack;
      end
    end
    req = '0;
    chk("ack_count", 32'(got), 32'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 30) begin
      cyc();
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic write(input int ch, input logic [W-1:0] v, input logic [W-1:0] exp);
    data_in[ch*W +: W] = v;
    push(ch, exp);
    req[ch] = 1'b1;
    wait_acks(1, 1'b1);
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    req = '0;
    data_in = '0;
    do_reset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_data", 32'(dac_data), 32'd0);
    chk("rst_addr", 32'(dac_addr), 32'd0);
    chk("rst_wr_n", 32'(dac_wr_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic transaction timing, cycle index counted from the grant edge.
    data_in[0 +: W] = 12'h000;
    push(0, 12'h800);
    req = 4'b0001;
    cyc();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_c1_wr_n", 32'(dac_wr_n), 32'd1);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    req = '0;
    cyc(); chk("t1_c2_wr_n", 32'(dac_wr_n), 32'd0); chk("t1_c2_ack", 32'(ack), 32'd0);
    cyc(); chk("t1_c3_wr_n", 32'(dac_wr_n), 32'd0);
    cyc(); chk("t1_c4_wr_n", 32'(dac_wr_n), 32'd1); chk("t1_c4_busy", 32'(busy), 32'd1);
    cyc(); chk("t1_c5_busy", 32'(busy), 32'd0); chk("t1_c5_data", 32'(dac_data), 32'h800);
    chk("t1_strobes", 32'(strobes), 32'd2);

    // Conversion corners on channel 2.
    write(2, 12'h7FF, 12'hFFF);
    write(2, 12'hCA3, 12'h4A3);
    write(2, 12'h001, 12'h801);
`ifdef DAC_SYM_CLAMP_EN
    write(2, 12'h800, 12'h001);
`else
    write(2, 12'h800, 12'h000);
`endif
    chk("conv_idle_addr", 32'(dac_addr), 32'd2);

    // Round robin under continuous request, pointer restarted by reset.
    do_reset();
    for (int k = 0; k < N; k++) data_in[k*W +: W] = W'(k * 12'h100);
    push(0, 12'h800); push(1, 12'h900); push(2, 12'hA00); push(3, 12'hB00); push(0, 12'h800);
    req = 4'b1111;
    wait_acks(5, 1'b0);
    for (int k = 1; k < 5; k++) chk("rr_period", 32'(gc[k] - gc[k-1]), 32'd5);
    wait_idle();

    // Pointer to 2, then req=0011 must grant ch0 before ch1.
    write(1, 12'h055, 12'h855);
    data_in[0 +: W] = 12'h011;
    data_in[W +: W] = 12'h022;
    push(0, 12'h811); push(1, 12'h822);
    req = 4'b0011;
    wait_acks(2, 1'b1);
    wait_idle();

    // A request raised and dropped while busy is never granted.
    data_in[3*W +: W] = 12'h333;
    push(3, 12'hB33);
    req = 4'b1000;
    wait_acks(1, 1'b1);
    req[1] = 1'b1;
    cyc();
    cyc();
    req[1] = 1'b0;
    wait_idle();
    strobes = 0;
    a0 = acks_seen;
    for (int k = 0; k < 6; k++) cyc();
    chk("drop_no_strobe", 32'(strobes), 32'd0);
    chk("drop_no_ack", 32'(acks_seen - a0), 32'd0);

    // Reset during the second strobe cycle aborts the write.
    data_in[0 +: W] = 12'h3C0;
    push(0, 12'hBC0);
    req = 4'b0001;
    wait_acks(1, 1'b1);
    cyc();
    cyc();
    chk("abort_pre_wr_n", 32'(dac_wr_n), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_wr_n", 32'(dac_wr_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data", 32'(dac_data), 32'd0);
    chk("abort_addr", 32'(dac_addr), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    a0 = acks_seen;
    for (int k = 0; k < 4; k++) cyc();
    chk("abort_no_ack", 32'(acks_seen - a0), 32'd0);
    // Pointer would be 1 without reset; 0 restart grants ch0 ahead of ch2.
    data_in[0 +: W] = 12'h010;
    data_in[2*W +: W] = 12'h7F0;
    push(0, 12'h810); push(2, 12'hFF0);
    req = 4'b0101;
    wait_acks(2, 1'b1);
    wait_idle();

    // Data changed after ack must not disturb the in-flight write.
    data_in[0 +: W] = 12'h123;
    push(0, 12'h923);
    req = 4'b0001;
    wait_acks(1, 1'b1);
    data_in[0 +: W] = 12'hABC;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_data", 32'(dac_data), 32'h923);
    end
    wait_idle();
    chk("post_data", 32'(dac_data), 32'h923);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
